// File: rtl/hex_digit_arbiter.sv
// hex_digit_arbiter: round-robin time-share of one 7-segment digit decoder.
// Each requester holds req[i] with a 4-bit code on data[4*i+3:4*i]. The winner's
// code is latched and shown for HOLD_CYCLES cycles, then the owner gets a
// one-cycle ack. Dropping req[owner] during the dwell abandons the grant (no ack).
//
// Ports:
//   CLOCK_50    system clock, rising edge
//   reset       asynchronous, active-high reset
//   req         per-requester request level
//   data        packed 4-bit codes, requester i at data[4*i+3:4*i]
//   ack         one-hot, one-cycle pulse after a full dwell
//   disp_code   code to the digit decoder (holds when disp_valid is low)
//   disp_valid  decoder enable; blank when low
//   owner       current/last granted requester index
//   busy        high while showing or acknowledging
module hex_digit_arbiter #(
    parameter int unsigned NREQ        = 4,
    parameter int unsigned HOLD_CYCLES = 50000000,
    parameter int unsigned CW          = 26
) (
    input  logic                      CLOCK_50,
    input  logic                      reset,
    input  logic [NREQ-1:0]           req,
    input  logic [4*NREQ-1:0]         data,
    output logic [NREQ-1:0]           ack,
    output logic [3:0]                disp_code,
    output logic                      disp_valid,
    output logic [$clog2(NREQ)-1:0]   owner,
    output logic                      busy
);

    localparam int unsigned IW = $clog2(NREQ);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SHOW = 2'd1,
        ACK  = 2'd2
    } state_t;

    state_t          state, state_nxt;
    logic [CW-1:0]   cnt, cnt_nxt;
    logic [IW-1:0]   last_owner, last_owner_nxt;
    logic [IW-1:0]   owner_nxt;
    logic [3:0]      code_nxt;
    logic            valid_nxt;
    logic            busy_nxt;
    logic [NREQ-1:0] ack_nxt;

    logic [3:0]      codes [NREQ];
    logic [IW-1:0]   pick;
    logic            pick_valid;

    // Unpack the flat code bus into one entry per requester
    always_comb begin
        for (int unsigned i = 0; i < NREQ; i++) begin
            codes[i] = data[4*i +: 4];
        end
    end

    // Round-robin search starting just after the previous owner, wrapping at NREQ-1
    always_comb begin
        pick_valid = 1'b0;
        pick       = '0;
        for (int unsigned k = 1; k <= NREQ; k++) begin
            if (!pick_valid && req[IW'((32'(last_owner) + k) % NREQ)]) begin
                pick_valid = 1'b1;
                pick       = IW'((32'(last_owner) + k) % NREQ);
            end
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_nxt      = state;
        cnt_nxt        = cnt;
        last_owner_nxt = last_owner;
        owner_nxt      = owner;
        code_nxt       = disp_code;
        valid_nxt      = disp_valid;
        busy_nxt       = busy;
        ack_nxt        = '0;

        unique case (state)
            IDLE: begin
                if (pick_valid) begin
                    state_nxt = SHOW;
                    owner_nxt = pick;
                    code_nxt  = codes[pick];
                    valid_nxt = 1'b1;
                    busy_nxt  = 1'b1;
                    cnt_nxt   = CW'(HOLD_CYCLES - 1);
                end
            end
            SHOW: begin
                // Abort wins over dwell completion on the same edge
                if (!req[owner]) begin
                    state_nxt      = IDLE;
                    valid_nxt      = 1'b0;
                    busy_nxt       = 1'b0;
                    last_owner_nxt = owner;
                    cnt_nxt        = '0;
                end else if (cnt == '0) begin
                    state_nxt      = ACK;
                    valid_nxt      = 1'b0;
                    ack_nxt        = NREQ'(1) << owner;
                    last_owner_nxt = owner;
                end else begin
                    cnt_nxt = cnt - CW'(1);
                end
            end
            ACK: begin
                state_nxt = IDLE;
                busy_nxt  = 1'b0;
            end
            default: begin
                state_nxt = IDLE;
                valid_nxt = 1'b0;
                busy_nxt  = 1'b0;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= '0;
            last_owner <= IW'(NREQ - 1);
            owner      <= IW'(NREQ - 1);
            disp_code  <= '0;
            disp_valid <= 1'b0;
            busy       <= 1'b0;
            ack        <= '0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            last_owner <= last_owner_nxt;
            owner      <= owner_nxt;
            disp_code  <= code_nxt;
            disp_valid <= valid_nxt;
            busy       <= busy_nxt;
            ack        <= ack_nxt;
        end
    end

endmodule

// File: tb/tb_hex_digit_arbiter.sv
// tb_hex_digit_arbiter: directed scenarios plus randomized traffic for
// hex_digit_arbiter (NREQ=4, HOLD_CYCLES=4), checked every cycle against a
// timestamp-based reference model of the grant/dwell/ack timeline.
module tb_hex_digit_arbiter;

    localparam int unsigned NREQ = 4;
    localparam int unsigned HOLD = 4;
    localparam int unsigned CW   = 3;
    localparam int unsigned IW   = 2;

    logic                 CLOCK_50 = 1'b0;
    logic                 reset;
    logic [NREQ-1:0]      req;
    logic [4*NREQ-1:0]    data;
    logic [NREQ-1:0]      ack;
    logic [3:0]           disp_code;
    logic                 disp_valid;
    logic [IW-1:0]        owner;
    logic                 busy;

    hex_digit_arbiter #(
        .NREQ        (NREQ),
        .HOLD_CYCLES (HOLD),
        .CW          (CW)
    ) dut (
        .CLOCK_50   (CLOCK_50),
        .reset      (reset),
        .req        (req),
        .data       (data),
        .ack        (ack),
        .disp_code  (disp_code),
        .disp_valid (disp_valid),
        .owner      (owner),
        .busy       (busy)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Reference model: a grant made at edge g_t is shown while (edge - g_t) < HOLD,
    // acknowledged at HOLD, and the arbiter is free again after HOLD+1.
    int              n;
    int              g_t;
    bit              m_active;
    int              m_owner;
    int              m_last;
    logic [3:0]      m_code;
    bit              m_valid;
    bit              m_busy;
    logic [NREQ-1:0] m_ack;

    task automatic model_reset();
        m_active = 1'b0;
        m_last   = NREQ - 1;
        m_owner  = NREQ - 1;
        m_code   = 4'h0;
        m_valid  = 1'b0;
        m_busy   = 1'b0;
        m_ack    = '0;
    endtask

    task automatic model_edge();
        int e;
        n++;
        m_ack = '0;
        if (m_active) begin
            e = n - g_t;
            if (e <= int'(HOLD) && !req[m_owner]) begin
                m_active = 1'b0;
                m_last   = m_owner;
                m_valid  = 1'b0;
                m_busy   = 1'b0;
            end else if (e == int'(HOLD)) begin
                m_valid        = 1'b0;
                m_ack[m_owner] = 1'b1;
                m_last         = m_owner;
            end else if (e > int'(HOLD)) begin
                m_active = 1'b0;
                m_busy   = 1'b0;
            end
        end else if (req != '0) begin
            for (int k = 1; k <= int'(NREQ); k++) begin
                if (req[(m_last + k) % NREQ]) begin
                    m_owner = (m_last + k) % NREQ;
                    break;
                end
            end
            m_code   = data[4*m_owner +: 4];
            g_t      = n;
            m_active = 1'b1;
            m_valid  = 1'b1;
            m_busy   = 1'b1;
        end
    endtask

    task automatic compare_all();
        check("disp_valid", 32'(disp_valid), 32'(m_valid));
        check("disp_code",  32'(disp_code),  32'(m_code));
        check("ack",        32'(ack),        32'(m_ack));
        check("busy",       32'(busy),       32'(m_busy));
        check("owner",      32'(owner),      32'(m_owner));
    endtask

    task automatic step();
        @(posedge CLOCK_50);
        if (!reset) model_edge();
        #1;
        compare_all();
    endtask

    task automatic assert_reset();
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        compare_all();
    endtask

    task automatic release_reset();
        @(posedge CLOCK_50);
        @(negedge CLOCK_50);
        reset = 1'b0;
    endtask

    task automatic do_reset();
        assert_reset();
        release_reset();
    endtask

    initial begin
        int cv;
        int cb;
        int ca;
        bit prev;
        int q_owner[$];
        int q_code[$];
        int q_time[$];
        int exp_o[5];
        int exp_c[5];

        n     = 0;
        g_t   = 0;
        reset = 1'b1;
        req   = '0;
        data  = '0;
        model_reset();
        #3;
        compare_all();
        check("reset_owner", 32'(owner), 32'(3));
        release_reset();

        // Single requester: 4-cycle dwell, one ack, busy for HOLD+1 cycles
        req  = 4'b0001;
        data = 16'h0007;
        cv = 0; cb = 0; ca = 0;
        for (int c = 0; c < 8; c++) begin
            step();
            if (c == 0) begin
                check("t1_owner", 32'(owner), 32'(0));
                check("t1_code",  32'(disp_code), 32'(7));
            end
            cv += int'(disp_valid);
            cb += int'(busy);
            if (ack == 4'b0001) ca++;
            if (ack != '0) req = '0;
        end
        check("t1_valid_cycles", 32'(cv), 32'(4));
        check("t1_busy_cycles",  32'(cb), 32'(5));
        check("t1_ack_cycles",   32'(ca), 32'(1));

        // All four requesting: round-robin order and 6-cycle grant period
        do_reset();
        req  = 4'b1111;
        data = 16'h4321;
        prev = 1'b0;
        for (int c = 0; c < 32; c++) begin
            step();
            if (disp_valid && !prev) begin
                q_owner.push_back(int'(owner));
                q_code.push_back(int'(disp_code));
                q_time.push_back(c);
            end
            prev = disp_valid;
        end
        exp_o = '{0, 1, 2, 3, 0};
        exp_c = '{1, 2, 3, 4, 1};
        check("t2_ngrants", 32'(q_owner.size() >= 5), 32'(1));
        for (int i = 0; i < 5 && i < q_owner.size(); i++) begin
            check("t2_owner_seq", 32'(q_owner[i]), 32'(exp_o[i]));
            check("t2_code_seq",  32'(q_code[i]),  32'(exp_c[i]));
            if (i > 0) check("t2_period", 32'(q_time[i] - q_time[i-1]), 32'(6));
        end

        // Code latched at grant is frozen while data changes
        do_reset();
        req  = 4'b0100;
        data = 16'h0A00;
        step();
        check("t3_owner", 32'(owner), 32'(2));
        data = 16'h0B00;
        for (int c = 0; c < 4; c++) begin
            step();
            check("t3_frozen", 32'(disp_code), 32'(4'hA));
        end
        check("t3_ack", 32'(ack), 32'(4'b0100));
        req = '0;
        step();

        // Abort: drop req[1] after two SHOW cycles, next search starts at 2
        do_reset();
        req  = 4'b0010;
        data = 16'h5555;
        step();
        step();
        step();
        req = '0;
        step();
        check("t4_abort_valid", 32'(disp_valid), 32'(0));
        check("t4_abort_ack",   32'(ack),        32'(0));
        req = 4'b1111;
        step();
        check("t4_next_owner", 32'(owner), 32'(2));
        req = '0;
        for (int c = 0; c < 3; c++) step();

        // Wrap-around after requester 3 is served
        do_reset();
        req  = 4'b1000;
        data = 16'h9000;
        step();
        check("t5_owner3", 32'(owner), 32'(3));
        for (int c = 0; c < 4; c++) step();
        check("t5_ack", 32'(ack), 32'(4'b1000));
        req = '0;
        step();
        req  = 4'b1001;
        data = 16'h9006;
        step();
        check("t5_wrap_owner", 32'(owner), 32'(0));
        check("t5_wrap_code",  32'(disp_code), 32'(6));
        req = '0;
        for (int c = 0; c < 3; c++) step();

        // Asynchronous reset in the middle of SHOW
        do_reset();
        req  = 4'b0010;
        data = 16'h00C0;
        step();
        step();
        step();
        assert_reset();
        check("t6_rst_valid", 32'(disp_valid), 32'(0));
        check("t6_rst_busy",  32'(busy),       32'(0));
        check("t6_rst_ack",   32'(ack),        32'(0));
        check("t6_rst_owner", 32'(owner),      32'(3));
        release_reset();
        req = 4'b0100;
        step();
        check("t6_after_owner", 32'(owner), 32'(2));
        req = '0;
        for (int c = 0; c < 3; c++) step();

        // Randomized traffic with occasional resets
        do_reset();
        req = '0;
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < int'(NREQ); i++) begin
                if ($urandom_range(0, 7) == 0) req[i] = ~req[i];
                if (m_ack[i] && $urandom_range(0, 3) != 0) req[i] = 1'b0;
            end
            data = 16'($urandom);
            if ($urandom_range(0, 399) == 0) begin
                assert_reset();
                release_reset();
            end
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/hex_digit_arbiter.md
Name: hex_digit_arbiter

Overview:
Time-shares a single 7-segment digit decoder between NREQ requesters, so that several sources can use one HEX digit. Each requester presents a 4-bit code and holds a request line. The arbiter grants round-robin, latches the granted code, and drives it to the decoder for a fixed dwell time. It then returns a one-cycle acknowledge to the owner. It sits between the board-level sources (KEY logic, counters, status) and the combinational digit decoder feeding HEX0.

Parameters:
NREQ, 4, number of requesters (2..8); owner index width IW = clog2(NREQ)
HOLD_CYCLES, 50000000, dwell time in clock cycles per grant (1 s at 50 MHz); must be >= 1
CW, 26, dwell counter width; must satisfy 2^CW >= HOLD_CYCLES

Ports:
CLOCK_50  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-high reset
req  input  NREQ  per-requester request level
data  input  4*NREQ  packed codes; requester i uses data[4*i+3:4*i]
ack  output  NREQ  one-hot, one-cycle pulse: owner's code was shown for the full dwell
disp_code  output  4  code to the digit decoder
disp_valid  output  1  high while disp_code is being shown; decoder blanks when low
owner  output  IW  index of current/last granted requester
busy  output  1  high in SHOW and ACK states

Behaviour:
- One clock domain, CLOCK_50. Reset is asynchronous and active-high.
- All outputs are registered. There is no combinational path from req or data to any output.
- Reset values:
  - state = IDLE; ack = 0; disp_code = 0; disp_valid = 0; busy = 0; counter = 0.
  - last_owner = NREQ-1, so requester 0 has first priority after reset.
  - owner = NREQ-1.
- States: IDLE, SHOW, ACK.
- IDLE:
  - If req == 0, stay in IDLE.
  - Otherwise pick the first i with req[i]=1, searching cyclically from last_owner+1.
  - On that edge: owner <= i; disp_code <= data[4i+3:4i]; disp_valid <= 1; busy <= 1; counter <= HOLD_CYCLES-1; state <= SHOW.
  - Latency: req seen high at edge k gives disp_valid high from edge k onward.
- SHOW:
  - disp_code is frozen. Changes on data are ignored.
  - Counter decrements by 1 per cycle.
  - When counter == 0: disp_valid <= 0; ack[owner] <= 1; last_owner <= owner; state <= ACK.
  - Dwell: disp_valid is high for exactly HOLD_CYCLES cycles.
- Abort in SHOW:
  - If req[owner] is sampled low in SHOW before the counter reaches 0: disp_valid <= 0; last_owner <= owner; no ack; state <= IDLE.
  - The abort check takes precedence over counter == 0 on the same edge.
- ACK:
  - Lasts exactly one cycle with ack[owner] = 1 and busy = 1.
  - No grant is made in ACK.
  - Next state is IDLE; ack returns to 0.
  - The owner must drop req during the ACK cycle. If req is still high in the following IDLE cycle, that is treated as a new request, subject to round-robin.
- Round-robin:
  - The previous owner has the lowest priority on the next arbitration.
  - The search wraps from NREQ-1 to 0.
  - A single active requester is regranted on every free IDLE cycle.
- Throughput: minimum period per grant is HOLD_CYCLES+2 cycles (SHOW, ACK, IDLE).
- HOLD_CYCLES = 1: SHOW lasts one cycle and the counter is loaded with 0.
- owner holds its value outside SHOW and ACK, for debug LEDs.
- disp_code holds its last value when disp_valid = 0.
- Reset asserted mid-SHOW or mid-ACK forces all reset values immediately, asynchronously. No ack is issued for the interrupted grant.

Test Plan (HOLD_CYCLES=4, NREQ=4):
- Reset, then req=0001, data[3:0]=4'h7 -> disp_valid high for 4 cycles with disp_code=7 and owner=0; ack=0001 for 1 cycle; busy high for 5 cycles.
- req=1111 held with codes 1,2,3,4 -> grants in order owner 0,1,2,3,0; disp_code sequence 1,2,3,4,1; grant period 6 cycles.
- Grant to requester 2, then change data[11:8] from A to B mid-SHOW -> disp_code stays A for the full dwell.
- Grant to requester 1, then drop req[1] after 2 SHOW cycles -> disp_valid falls on the next edge, no ack, and the next arbitration starts the search at 2.
- After requester 3 is served (last_owner=3), assert req=1001 -> requester 0 granted (wrap-around).
- Assert reset during cycle 3 of SHOW -> disp_valid, busy and ack go to 0 immediately and owner=3. After release, req=0100 gives owner=2 after one edge.
